// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: default line settings, frame shape,
// transmitter state encoding and the clocks-per-bit helper.
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT     = 9600;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Clocks per serial bit, truncated by integer division.
    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte-source handshake and line-side status of the shared UART transmitter.
// master: the byte sources side; slave: the scheduler.
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    localparam int GW = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic [GW-1:0]      grant_id;
    logic               busy;
    logic               frame_done;
    logic               tx_uart;

    modport master (
        output req_valid, req_data,
        input  req_ready, grant_id, busy, frame_done, tx_uart
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, grant_id, busy, frame_done, tx_uart
    );

endinterface

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: accepts a byte on start while idle, then drives start bit,
// eight data bits LSB first and the stop bit, each BIT_CYCLES clocks long.
// All outputs are registered so the serial line never glitches.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = 5208
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(BIT_CYCLES - 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    tx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    // Frame sequencer: baud/bit counting, shifting and the registered line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b1;
                    if (start) begin
                        shift_reg <= data;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // done is registered, so raise it one clock early to land
                    // on the final clock of the last stop bit.
                    if (baud_cnt == BAUD_PRE && bit_cnt == STOP_LAST) begin
                        done <= 1'b1;
                    end
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 transmit line between N_REQ byte
// sources. Requests are only looked at while the serialiser is idle; the
// winner gets a one-cycle req_ready and its byte goes straight into the core.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
    parameter int BAUD     = BAUD_DEFAULT,
    parameter int N_REQ    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_sched_if.slave  bus
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
    localparam int GW         = $clog2(N_REQ);

    // After reset the pointer sits on the last source so source 0 wins first.
    localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);

    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        winner;
    logic [GW-1:0]        cand;
    logic                 found;
    logic                 accept;
    logic                 core_busy;
    logic [DATA_BITS-1:0] winner_data;

    // Search upward from the source after the last grant, wrapping around.
    always_comb begin
        winner = last_grant;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = GW'((int'(last_grant) + i) % N_REQ);
            if (!found && bus.req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Accept only while idle and out of reset; ready is one-hot on the winner.
    always_comb begin
        accept        = rst_n && !core_busy && (|bus.req_valid);
        winner_data   = bus.req_data[{winner, 3'b000} +: DATA_BITS];
        bus.req_ready = accept ? (N_REQ'(1) << winner) : '0;
    end

    // Grant bookkeeping: reported grant and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant   <= LAST_INIT;
            bus.grant_id <= '0;
        end else if (accept) begin
            last_grant   <= winner;
            bus.grant_id <= winner;
        end
    end

    assign bus.busy = core_busy;

    uart_tx_core #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .data  (winner_data),
        .tx    (bus.tx_uart),
        .busy  (core_busy),
        .done  (bus.frame_done)
    );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised scoreboard bench for uart_tx_sched with 16 clocks per bit.
// A cycle-level reference model predicts handshakes, line level and status
// from the frame rules; a separate monitor decodes the serial line and
// compares each received byte and grant against the expected-frame queue.
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int BC    = 16;
    localparam int FRAME = 10 * BC;

    typedef struct {
        int         id;
        logic [7:0] data;
    } frame_t;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    frame_t exp_q[$];

    bit refill [N];
    bit rand_data;
    bit rand_mode;

    uart_tx_sched_if #(.N_REQ(N)) bus ();

    uart_tx_sched #(
        .CLK_FREQ (160),
        .BAUD     (10),
        .N_REQ    (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid source searching upward from last+1.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input int src, input logic [7:0] d, input bit keep);
        bus.req_data[8*src +: 8] = d;
        bus.req_valid[src]       = 1'b1;
        refill[src]              = keep;
    endtask

    // One clock of source behaviour: consume grants, optionally raise new requests.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            logic [N-1:0] r;
            @(negedge clk);
            r = bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if (!refill[i]) bus.req_valid[i] = 1'b0;
                    else if (rand_data) bus.req_data[8*i +: 8] = 8'($urandom);
                end
            end
            if (rand_mode) begin
                for (int i = 0; i < N; i++) begin
                    if (!bus.req_valid[i] && $urandom_range(0, 99) < 2) begin
                        applyStimulus(i, 8'($urandom), 1'($urandom_range(0, 1)));
                    end
                end
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        bit reached;
        reached = 1'b0;
        for (int k = 0; k < max_cycles && !reached; k++) begin
            step(1);
            if (bus.req_valid == '0 && bus.busy == 1'b0) reached = 1'b1;
        end
        step(3);
        checkOutput("idle_reached", 32'(reached), 32'd1);
    endtask

    // Reference model: frame timing and arbitration from the frame rules.
    initial begin : model
        int         cyc;
        bit         armed;
        bit         have_acc;
        int         acc;
        int         last;
        int         w;
        bit         in_frame;
        logic [9:0] fbits;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_tx;
        logic [N-1:0] exp_ready;
        frame_t     f;
        cyc = 0; armed = 0; have_acc = 0; acc = 0; last = N - 1; fbits = '1;
        forever begin
            @(negedge clk);
            cyc++;
            if (armed) begin
                in_frame  = have_acc && (cyc <= acc + FRAME);
                exp_busy  = in_frame && (cyc > acc);
                exp_done  = in_frame && (cyc == acc + FRAME);
                exp_tx    = (in_frame && cyc > acc) ? fbits[(cyc - acc - 1) / BC] : 1'b1;
                exp_ready = '0;
                if (rst_n && !in_frame && bus.req_valid != '0) begin
                    w         = rr_pick(bus.req_valid, last);
                    exp_ready = N'(1) << w;
                    f.id      = w;
                    f.data    = bus.req_data[8*w +: 8];
                    exp_q.push_back(f);
                    fbits     = {1'b1, f.data, 1'b0};
                    last      = w;
                    acc       = cyc;
                    have_acc  = 1'b1;
                end
                checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
                checkOutput("frame_done", 32'(bus.frame_done), 32'(exp_done));
                checkOutput("tx_uart", 32'(bus.tx_uart), 32'(exp_tx));
            end
            if (!rst_n) begin
                armed    = 1'b1;
                have_acc = 1'b0;
                last     = N - 1;
            end
        end
    end

    // Monitor: decode the serial line and score each frame against the queue.
    initial begin : monitor
        bit         active;
        int         cnt;
        frame_t     cur;
        logic [7:0] got;
        active = 0; cnt = 0; got = '0; cur.id = -1; cur.data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (active) begin
                cnt++;
                if (cnt == BC / 2) begin
                    checkOutput("start_bit", 32'(bus.tx_uart), 32'd0);
                end else if (cnt >= BC + BC / 2 && cnt < 9 * BC && (cnt % BC) == BC / 2) begin
                    got[(cnt - BC) / BC] = bus.tx_uart;
                end else if (cnt == 9 * BC + BC / 2) begin
                    checkOutput("stop_bit", 32'(bus.tx_uart), 32'd1);
                    checkOutput("rx_byte", 32'(got), 32'(cur.data));
                    checkOutput("grant_id", 32'(bus.grant_id), 32'(cur.id));
                end
                if (cnt == FRAME - 1) active = 1'b0;
            end else if (bus.tx_uart === 1'b0) begin
                active = 1'b1;
                cnt    = 0;
                got    = '0;
                checkOutput("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else begin
                    cur.id   = -1;
                    cur.data = '0;
                end
            end
        end
    end

    // Scenario sequence.
    initial begin : stimulus
        checks = 0; errors = 0;
        rand_data = 0; rand_mode = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) refill[i] = 0;

        // Reset with every source requesting, then continuous round-robin.
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) applyStimulus(i, 8'(8'h11 * i), 1);
        step(5);
        rst_n = 1'b1;
        step(5 * (FRAME + 1) + 10);
        for (int i = 0; i < N; i++) refill[i] = 0;
        wait_idle(1000);

        // Single byte from source 2.
        applyStimulus(2, 8'hA5, 0);
        wait_idle(400);

        // Only sources 1 and 3 requesting: they alternate.
        rand_data = 1;
        applyStimulus(1, 8'($urandom), 1);
        applyStimulus(3, 8'($urandom), 1);
        step(4 * (FRAME + 1));
        refill[1] = 0;
        refill[3] = 0;
        wait_idle(600);

        // Source 0 requests mid-frame of source 1 and must wait.
        applyStimulus(1, 8'h3C, 0);
        step(40);
        applyStimulus(0, 8'hC3, 0);
        wait_idle(600);

        // Reset during data bit 3 of a frame from source 2.
        applyStimulus(2, 8'h5A, 0);
        for (int k = 0; k < 10 && bus.req_valid[2]; k++) step(1);
        step(70);
        applyStimulus(0, 8'h81, 0);
        applyStimulus(3, 8'h7E, 0);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        wait_idle(800);

        // Random requests, data and refill behaviour.
        rand_mode = 1;
        step(3000);
        rand_mode = 0;
        for (int i = 0; i < N; i++) refill[i] = 0;
        wait_idle(2000);

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one 8N1 UART transmit line between N_REQ byte sources on the board.
- Each source offers a byte with a valid/ready handshake.
- The scheduler grants one source at a time and serialises the byte onto tx_uart at the configured baud rate.
- It is the transmit-side companion of the existing 9600-baud receiver and uses the same 50 MHz clock domain.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
BIT_CYCLES, CLK_FREQ/BAUD (5208), clocks per bit (derived localparam, integer division, not overridden directly)
N_REQ, 4, number of requesters (2..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  N_REQ  per-source "byte available"; source holds it and its data stable until its ready is seen
req_data  input  8*N_REQ  byte for source i on bits [8i+7:8i]
req_ready  output  N_REQ  one-hot one-cycle accept pulse
grant_id  output  $clog2(N_REQ)  index of the source being transmitted; holds last value when idle
busy  output  1  high from the accept cycle until the stop bit completes
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit
tx_uart  output  1  serial line, idle high

Behaviour:
- Reset (rst_n low at a clk edge), applied on the next edge:
  - tx_uart=1, busy=0, req_ready=0, frame_done=0, grant_id=0.
  - FSM to IDLE, baud counter and bit counter cleared.
  - Round-robin pointer set so source 0 has highest priority.
  - Asserting reset mid-frame aborts the frame: the line is high the following cycle and no frame_done is produced.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward (with wrap) from last_grant+1 mod N_REQ.
  - In that same cycle: req_ready[winner]=1, req_data byte latched into a shift register, grant_id<=winner, last_grant<=winner, busy<=1, next state START.
  - If no req_valid is high, stay in IDLE with tx_uart=1.
- START: tx_uart=0 for BIT_CYCLES clocks, beginning on the cycle after acceptance.
- DATA: 8 bits, LSB first, each held for BIT_CYCLES clocks. Bit counter 0..7; the shift register shifts right at the end of each bit.
- STOP: tx_uart=1 for BIT_CYCLES clocks. frame_done=1 on the final cycle; busy drops and the FSM returns to IDLE on the next edge.
- Frame length: exactly 10*BIT_CYCLES clocks from the first start-bit cycle to the end of the stop bit.
  - The IDLE cycle after STOP can accept a new request, so the minimum inter-frame line-high time is BIT_CYCLES+1 clocks.
- Baud counter: width $clog2(BIT_CYCLES). Counts 0..BIT_CYCLES-1 and wraps to 0 at the end of each bit; held at 0 in IDLE.
- req_valid is sampled only in IDLE. Valid changes outside IDLE are ignored, and no req_ready is issued outside IDLE.
- At most one req_ready bit is high in any cycle.
- Fairness: with all sources continuously valid, grants rotate 0,1,2,3,0,...
  - A source that drops valid is skipped without any idle penalty.
- tx_uart is driven from a register (no combinational glitches).

Decomposition:
- Shared package uart_pkg:
  - CLK_FREQ/BAUD defaults.
  - BIT_CYCLES function.
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Frame constants (DATA_BITS=8, STOP_BITS=1).
- One natural sub-module: uart_tx_core.
  - Contains the baud counter, bit counter, shift register and tx register.
  - Interface: start/byte in, busy/done out.
- uart_tx_sched itself holds the round-robin arbiter, the handshake and grant_id.

Test Plan:
- Bench override: CLK_FREQ=160, BAUD=10 gives BIT_CYCLES=16.
- Single byte: source 2 valid, data 8'hA5 -> req_ready[2] pulses once; tx_uart low 16 clocks; then 1,0,1,0,0,1,0,1 at 16 clocks each; high 16; frame_done at clock 160 after start; grant_id=2.
- Round-robin: all 4 valid continuously with bytes 8'h00,8'h11,8'h22,8'h33 -> grants 0,1,2,3,0; decoded stream 00 11 22 33 00; gap between stop end and next start = 1 clock.
- Skip: only sources 1 and 3 valid after a grant to 1 -> next grant 3, then 1; no idle cycles beyond the mandatory one.
- Hold-off: source 0 asserts valid mid-frame of source 1 -> no req_ready until the IDLE cycle after source 1's frame_done, then req_ready[0].
- Reset mid-frame: rst_n low for 1 clock during DATA bit 3 -> next cycle tx_uart=1, busy=0, frame_done never pulses; next grant goes to source 0.
- Reset values: hold rst_n low 5 clocks with all req_valid high -> req_ready=0, tx_uart=1, busy=0 throughout; first grant after release = source 0.
